// File: rtl/scanner_link_pkg.sv
// Shared constants and types for the scanner/control-station serial byte link.
package scanner_link_pkg;

    // Frame geometry; the wire protocol is byte framed.
    localparam int unsigned FRAME_BITS = 8;

    // The receiver discards this byte, so it doubles as the idle pattern.
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    // Command codes sent from the scanner controller.
    localparam logic [3:0] CMD_BUF50  = 4'd1;
    localparam logic [3:0] CMD_BUF80  = 4'd2;
    localparam logic [3:0] CMD_BUF90  = 4'd3;
    localparam logic [3:0] CMD_FULL   = 4'd4;
    localparam logic [3:0] CMD_FLUSH  = 4'd5;
    localparam logic [3:0] CMD_READY  = 4'd6;
    localparam logic [3:0] CMD_BINARY = 4'd7;
    localparam logic [3:0] CMD_ASCII  = 4'd8;

    // IDLE: choose next frame; CMD: code frame on the wire;
    // PAYLOAD: code 7 sent, payload byte must follow.
    typedef enum logic [1:0] {
        IDLE,
        CMD,
        PAYLOAD
    } link_state_e;

    // Holding register contents.
    typedef struct packed {
        logic [3:0] code;
        logic [7:0] data;
    } cmd_t;

    // A request is legal when its code is 1..8 and, for binary, the payload
    // cannot be mistaken for an idle frame.
    function automatic logic cmd_is_valid(input logic [3:0] code, input logic [7:0] data);
        return (code >= CMD_BUF50) && (code <= CMD_ASCII) &&
               !((code == CMD_BINARY) && (data == IDLE_BYTE));
    endfunction

endpackage

// File: rtl/link_piso.sv
// Parallel-load shift register; MSB leaves first, output taken straight from a flop.
module link_piso #(
    parameter int unsigned WIDTH = scanner_link_pkg::FRAME_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sr_q;

    // Load a new frame on the strobe, otherwise shift toward the MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else begin
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    assign dout = sr_q[WIDTH-1];

endmodule

// File: rtl/scanner_link_tx.sv
// Transmit end of the scanner/control-station byte link: accepts commands,
// holds one, and serialises them MSB-first into free-running 8-clock frames.
module scanner_link_tx #(
    parameter int unsigned FRAME_BITS = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [3:0]       cmd_code,
    input  logic [7:0]       cmd_data,
    output logic             cmd_ready,
    input  logic             ready_in,
    output logic             ser_out,
    output logic [2:0]       frame_slot,
    output logic             busy,
    output logic             err_bad_cmd,
    output logic [CNT_W-1:0] frames_sent
);
    import scanner_link_pkg::*;

    localparam logic [2:0] LAST_SLOT = 3'(FRAME_BITS - 1);

    logic [2:0]       slot_q;
    logic             last_slot;

    cmd_t             hold_q;
    logic             hold_valid_q;
    logic [7:0]       pay_q;

    link_state_e      state_q;
    link_state_e      state_d;
    logic [7:0]       load_byte;
    logic             take_hold;

    logic             frame_nz_q;
    logic             err_q;
    logic [CNT_W-1:0] sent_q;

    logic             cmd_ok;
    logic             accept;
    logic             reject;

    assign last_slot = (slot_q == LAST_SLOT);

    assign cmd_ok = cmd_is_valid(cmd_code, cmd_data);
    assign accept = cmd_valid && cmd_ready && cmd_ok;
    assign reject = cmd_valid && cmd_ready && !cmd_ok;

    // Free-running bit slot; never stalls, wraps 7 -> 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_q + 3'd1;
        end
    end

    // Holding register: filled on accept, emptied when moved into the shifter.
    // The payload is copied aside at that moment so a new accept cannot clobber it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            pay_q        <= IDLE_BYTE;
        end else if (take_hold) begin
            hold_valid_q <= 1'b0;
            pay_q        <= hold_q.data;
        end else if (accept) begin
            hold_q       <= '{code: cmd_code, data: cmd_data};
            hold_valid_q <= 1'b1;
        end
    end

    // Frame sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Choose the next frame at each frame boundary; the hold register is read
    // as registered, so a command accepted on the boundary waits a frame.
    always_comb begin
        state_d   = state_q;
        load_byte = IDLE_BYTE;
        take_hold = 1'b0;
        if (last_slot) begin
            case (state_q)
                IDLE: begin
                    if (hold_valid_q && ready_in) begin
                        load_byte = {4'b0000, hold_q.code};
                        take_hold = 1'b1;
                        state_d   = (hold_q.code == CMD_BINARY) ? PAYLOAD : CMD;
                    end
                end
                CMD: begin
                    state_d = IDLE;
                end
                PAYLOAD: begin
                    // Payload follows its code frame regardless of ready_in.
                    load_byte = pay_q;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Track whether the frame now shifting is non-idle, and count those frames
    // as they finish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_nz_q <= 1'b0;
            sent_q     <= '0;
        end else if (last_slot) begin
            frame_nz_q <= (load_byte != IDLE_BYTE);
            if (frame_nz_q) begin
                sent_q <= sent_q + 1'b1;
            end
        end
    end

    // Sticky error flag for rejected requests; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (reject) begin
            err_q <= 1'b1;
        end
    end

    link_piso #(
        .WIDTH (FRAME_BITS)
    ) u_piso (
        .clk  (clk),
        .rst  (rst),
        .load (last_slot),
        .din  (load_byte),
        .dout (ser_out)
    );

    assign cmd_ready   = !hold_valid_q;
    assign frame_slot  = slot_q;
    assign busy        = hold_valid_q || (state_q != IDLE) || frame_nz_q;
    assign err_bad_cmd = err_q;
    assign frames_sent = sent_q;

endmodule

// File: tb/tb_scanner_link_tx.sv
// Scoreboard bench for scanner_link_tx: accepted commands push their expected
// frame bytes; a monitor reassembles bytes from ser_out and pops/compares.
module tb_scanner_link_tx;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [3:0]       cmd_code = 4'd0;
    logic [7:0]       cmd_data = 8'd0;
    logic             ready_in = 1'b1;
    logic             cmd_ready;
    logic             ser_out;
    logic [2:0]       frame_slot;
    logic             busy;
    logic             err_bad_cmd;
    logic [CNT_W-1:0] frames_sent;

    scanner_link_tx #(
        .FRAME_BITS (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .ready_in    (ready_in),
        .ser_out     (ser_out),
        .frame_slot  (frame_slot),
        .busy        (busy),
        .err_bad_cmd (err_bad_cmd),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];

    // Monitor state
    int         frame_idx = 0;
    int         last_nz = -1;
    int         prev_nz = -1;
    int         nz_seen = 0;
    logic [7:0] mon_sh = 8'd0;
    logic [2:0] prev_slot = 3'd0;
    bit         prev_ok = 1'b0;
    bit         rand_ready = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reassemble frames from the wire and compare against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            mon_sh    = 8'd0;
            nz_seen   = 0;
            frame_idx = 0;
            last_nz   = -1;
            prev_nz   = -1;
            prev_ok   = 1'b0;
        end else begin
            if (prev_ok) begin
                logic [2:0] nxt;
                nxt = prev_slot + 3'd1;
                check("slot_step", 32'(frame_slot), 32'(nxt));
            end
            prev_slot = frame_slot;
            prev_ok   = 1'b1;
            mon_sh    = {mon_sh[6:0], ser_out};
            if (frame_slot == 3'd0) begin
                check("frames_sent", 32'(frames_sent), 32'(nz_seen[CNT_W-1:0]));
            end
            if (frame_slot == 3'd7) begin
                if (mon_sh != 8'd0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(mon_sh), 32'd0);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("frame_byte", 32'(mon_sh), 32'(e));
                    end
                    nz_seen++;
                    prev_nz = last_nz;
                    last_nz = frame_idx;
                end
                frame_idx++;
            end
        end
    end

    // Sample just after the falling edge, then drive for the next rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
        if (rand_ready) ready_in = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_slot(input logic [2:0] s);
        int n;
        n = 0;
        tick();
        while (frame_slot != s && n < 16) begin
            tick();
            n++;
        end
        if (frame_slot != s) check("wait_slot_timeout", 32'(frame_slot), 32'(s));
    endtask

    task automatic wait_frame(input int f);
        int n;
        n = 0;
        while (frame_idx < f && n < 300) begin
            tick();
            n++;
        end
        if (frame_idx < f) check("wait_frame_timeout", 32'(frame_idx), 32'(f));
    endtask

    function automatic bit legal(input logic [3:0] code, input logic [7:0] data);
        return (code >= 4'd1) && (code <= 4'd8) && !(code == 4'd7 && data == 8'd0);
    endfunction

    // Present a request until accepted; returns legality and the frame index of acceptance.
    task automatic send(input logic [3:0] code, input logic [7:0] data,
                        output bit ok, output int af);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_data  = data;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        ok = 1'b0;
        af = frame_idx;
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            ok = legal(code, data);
            if (ok) begin
                exp_q.push_back({4'd0, code});
                if (code == 4'd7) exp_q.push_back(data);
            end
            tick();
            cmd_valid = 1'b0;
        end
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_ser_out"}, 32'(ser_out), 32'd0);
        check({tag, "_frame_slot"}, 32'(frame_slot), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err_bad_cmd), 32'd0);
        check({tag, "_frames_sent"}, 32'(frames_sent), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int af;
        int g;
        int fs0;
        int nz0;
        int cnt_a;
        int cnt_b;
        bit err_exp;
        logic [3:0] c;
        logic [7:0] d;

        // Reset values
        repeat (3) tick();
        reset_vals("reset");
        rst = 1'b1;

        // Idle: nothing on the wire
        cnt_a = 0;
        cnt_b = 0;
        repeat (32) begin
            tick();
            if (ser_out) cnt_a++;
            if (busy) cnt_b++;
        end
        check("idle_ser_out_ones", 32'(cnt_a), 32'd0);
        check("idle_busy_cycles", 32'(cnt_b), 32'd0);
        check("idle_frames_sent", 32'(frames_sent), 32'd0);

        // Single command accepted at slot 2
        ready_in = 1'b1;
        wait_slot(3'd2);
        send(4'd3, 8'h5A, ok, af);
        check("c3_ready_low", 32'(cmd_ready), 32'd0);
        check("c3_busy", 32'(busy), 32'd1);
        wait_slot(3'd7);
        check("c3_ready_before_load", 32'(cmd_ready), 32'd0);
        tick();
        check("c3_ready_after_load", 32'(cmd_ready), 32'd1);
        check("c3_busy_shifting", 32'(busy), 32'd1);
        wait_frame(af + 2);
        check("c3_latency", 32'(last_nz), 32'(af + 1));
        tick();
        check("c3_frames_sent", 32'(frames_sent), 32'd1);

        // Binary on a frame boundary; ready_in dropped during the code frame
        wait_frame(frame_idx + 2);
        wait_slot(3'd7);
        fs0 = int'(frames_sent);
        send(4'd7, 8'hA5, ok, af);
        wait_frame(af + 1);
        wait_slot(3'd2);
        ready_in = 1'b0;
        wait_frame(af + 3);
        check("bin_code_frame_idx", 32'(prev_nz), 32'(af + 1));
        check("bin_payload_frame_idx", 32'(last_nz), 32'(af + 2));
        tick();
        check("bin_frames_sent", 32'(frames_sent), 32'(fs0 + 2));

        // Held command blocked by ready_in
        ready_in = 1'b0;
        fs0 = int'(frames_sent);
        nz0 = nz_seen;
        send(4'd6, 8'h00, ok, af);
        wait_frame(af + 4);
        check("blk_cmd_ready", 32'(cmd_ready), 32'd0);
        check("blk_busy", 32'(busy), 32'd1);
        check("blk_no_frames", 32'(nz_seen), 32'(nz0));
        check("blk_frames_sent", 32'(frames_sent), 32'(fs0));
        wait_slot(3'd3);
        ready_in = 1'b1;
        g = frame_idx;
        wait_frame(g + 2);
        check("blk_release_frame_idx", 32'(last_nz), 32'(g + 1));

        // Rejections
        wait_frame(frame_idx + 2);
        check("rej_err_clear", 32'(err_bad_cmd), 32'd0);
        nz0 = nz_seen;
        fs0 = int'(frames_sent);
        send(4'd9, 8'h11, ok, af);
        check("rej9_err", 32'(err_bad_cmd), 32'd1);
        check("rej9_ready", 32'(cmd_ready), 32'd1);
        send(4'd0, 8'h22, ok, af);
        check("rej0_err", 32'(err_bad_cmd), 32'd1);
        check("rej0_ready", 32'(cmd_ready), 32'd1);
        send(4'd7, 8'h00, ok, af);
        check("rej7z_err", 32'(err_bad_cmd), 32'd1);
        check("rej7z_ready", 32'(cmd_ready), 32'd1);
        repeat (24) tick();
        check("rej_no_frames", 32'(nz_seen), 32'(nz0));
        check("rej_frames_sent", 32'(frames_sent), 32'(fs0));
        check("rej_busy", 32'(busy), 32'd0);

        // Reset in the middle of a 0x05 frame
        send(4'd5, 8'h00, ok, af);
        wait_frame(af + 1);
        wait_slot(3'd4);
        rst = 1'b0;
        #1;
        exp_q.delete();
        reset_vals("midrst");
        tick();
        tick();
        rst = 1'b1;
        repeat (24) tick();
        check("midrst_no_frames", 32'(nz_seen), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);

        // Randomised traffic with a flapping ready_in
        err_exp = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 10)) tick();
            g = $urandom_range(0, 9);
            if (g < 8) c = 4'(g + 1);
            else if ($urandom_range(0, 1) == 0) c = 4'd0;
            else c = 4'($urandom_range(9, 15));
            if (c == 4'd7 && $urandom_range(0, 3) == 0) d = 8'h00;
            else d = 8'($urandom_range(0, 255));
            send(c, d, ok, af);
            if (!legal(c, d)) begin
                err_exp = 1'b1;
                check("rnd_reject_ready", 32'(cmd_ready), 32'd1);
            end
            check("rnd_err", 32'(err_bad_cmd), 32'(err_exp));
        end
        rand_ready = 1'b0;
        ready_in = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 400) begin
            tick();
            g++;
        end
        check("rnd_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_busy_end", 32'(busy), 32'd0);
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
